// File: rtl/formula_pkg.sv
// rtl/formula_pkg.sv - shared types, width defaults and counter helper for the formula result checker
package formula_pkg;

    localparam int default_width     = 8;
    localparam int default_width_out = 2 * default_width + 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FAIL = 2'd2
    } state_t;

    // Increments a counter of w bits (w <= 32), holding it at all-ones once reached.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [32:0] lim;
        lim = (33'd1 << w) - 33'd1;
        return ({1'b0, v} >= lim) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/formula_exp_fifo.sv
// rtl/formula_exp_fifo.sv - in-order expected-value FIFO with wrap-bit pointers
module formula_exp_fifo
    import formula_pkg::*;
#(
    parameter int width_out = default_width_out,
    parameter int depth     = 16,
    localparam int ptr_w    = $clog2(depth) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 push,
    input  logic                 pop,
    input  logic [width_out-1:0] din,
    output logic [width_out-1:0] dout,
    output logic                 full,
    output logic                 empty,
    output logic [ptr_w-1:0]     count
);

    localparam int addr_w = ptr_w - 1;

    logic [width_out-1:0] mem [depth];
    logic [ptr_w-1:0]     wr_ptr;
    logic [ptr_w-1:0]     rd_ptr;
    logic [ptr_w-1:0]     wr_next;
    logic [ptr_w-1:0]     rd_next;
    logic                 do_push;
    logic                 do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ptr_w-1] != rd_ptr[ptr_w-1]) &&
                   (wr_ptr[addr_w-1:0] == rd_ptr[addr_w-1:0]);

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;

    assign wr_next = wr_ptr + {{(ptr_w-1){1'b0}}, do_push};
    assign rd_next = rd_ptr + {{(ptr_w-1){1'b0}}, do_pop};
    assign dout    = mem[rd_ptr[addr_w-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            count  <= wr_next - rd_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[addr_w-1:0]] <= din;
        end
    end

endmodule

// File: rtl/formula_result_checker.sv
// rtl/formula_result_checker.sv - compares formula results against queued expectations and keeps statistics
module formula_result_checker
    import formula_pkg::*;
#(
    parameter int width     = default_width,
    parameter int width_out = 2 * width + 6,
    parameter int depth     = 16,
    parameter int cnt_w     = 16,
    localparam int ptr_w    = $clog2(depth) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        vld_in,
    input  logic signed [width_out-1:0] exp_in,
    input  logic                        vld_out,
    input  logic signed [width_out-1:0] q,
    output logic [cnt_w-1:0]            pass_cnt,
    output logic [cnt_w-1:0]            fail_cnt,
    output logic [cnt_w-1:0]            res_idx,
    output logic [ptr_w-1:0]            pending,
    output logic                        err_vld,
    output logic [cnt_w-1:0]            err_idx,
    output logic [width_out-1:0]        err_exp,
    output logic [width_out-1:0]        err_act,
    output logic                        overflow,
    output logic                        underflow,
    output logic [1:0]                  state
);

    logic [width_out-1:0] head;
    logic                 full;
    logic                 empty;
    logic                 pop_ok;
    logic                 push_ok;
    logic                 mismatch;
    logic                 overflow_evt;
    logic                 underflow_evt;
    logic [ptr_w-1:0]     pend_next;
    state_t               state_q;
    state_t               state_next;

    formula_exp_fifo #(
        .width_out (width_out),
        .depth     (depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (vld_in),
        .pop   (vld_out),
        .din   (exp_in),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (pending)
    );

    assign pop_ok        = vld_out && !empty;
    assign push_ok       = vld_in && (!full || pop_ok);
    assign mismatch      = pop_ok && (head != q);
    assign overflow_evt  = vld_in && !push_ok;
    assign underflow_evt = vld_out && empty;
    assign pend_next     = pending + {{(ptr_w-1){1'b0}}, push_ok} - {{(ptr_w-1){1'b0}}, pop_ok};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            res_idx   <= '0;
            err_vld   <= 1'b0;
            err_idx   <= '0;
            err_exp   <= '0;
            err_act   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            res_idx   <= '0;
            err_vld   <= 1'b0;
            err_idx   <= '0;
            err_exp   <= '0;
            err_act   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (pop_ok) begin
                if (mismatch) begin
                    fail_cnt <= cnt_w'(sat_inc(32'(fail_cnt), cnt_w));
                    // Only the first failure is kept; later ones are counted but not captured.
                    if (!err_vld) begin
                        err_vld <= 1'b1;
                        err_idx <= res_idx;
                        err_exp <= head;
                        err_act <= q;
                    end
                end else begin
                    pass_cnt <= cnt_w'(sat_inc(32'(pass_cnt), cnt_w));
                end
            end
            if (vld_out) begin
                res_idx <= cnt_w'(sat_inc(32'(res_idx), cnt_w));
            end
            if (overflow_evt) begin
                overflow <= 1'b1;
            end
            if (underflow_evt) begin
                underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            S_IDLE, S_BUSY: begin
                if (mismatch || overflow_evt || underflow_evt) begin
                    state_next = S_FAIL;
                end else if (pend_next != '0) begin
                    state_next = S_BUSY;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_FAIL:  state_next = S_FAIL;
            default: state_next = S_IDLE;
        endcase
    end

    assign state = state_q;

endmodule

// File: doc/formula_result_checker.md
Name: formula_result_checker

Overview:
- Synthesizable response-side companion to the formula pipeline.
- Records the expected result for every issued operand set (vld_in) in an in-order FIFO.
- Pops and compares one entry against q on every vld_out; keeps pass/fail statistics and captures the first mismatch.
- Sits beside the formula DUT for on-chip self-check; the DUT pipeline latency is unknown to it and absorbed by the FIFO.

Parameters:
- width, 8, operand width of the formula block
- width_out, 2*width+6, result width of q
- depth, 16, expected-value FIFO entries; power of two, >= 2
- cnt_w, 16, width of all statistic counters

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- clear  in  1  synchronous clear of FIFO, counters, sticky flags and error capture
- vld_in  in  1  operand set issued to formula this cycle; push exp_in
- exp_in  in  width_out  signed expected result for the issue
- vld_out  in  1  formula result valid this cycle; pop and compare
- q  in  width_out  signed formula result
- pass_cnt  out  cnt_w  matching results
- fail_cnt  out  cnt_w  mismatching results
- res_idx  out  cnt_w  results received since reset/clear
- pending  out  $clog2(depth)+1  entries currently in FIFO
- err_vld  out  1  first-error capture valid
- err_idx  out  cnt_w  res_idx value of first failing result
- err_exp  out  width_out  expected value at first failure
- err_act  out  width_out  actual q at first failure
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: vld_out while FIFO empty
- state  out  2  status FSM state

Behaviour:
- Reset (rst=0, async): all outputs 0; FIFO empty; state=S_IDLE. Release is sampled on clk.
- clear=1 has the same effect as reset but is synchronous. It has priority over vld_in and vld_out in the same cycle, which are dropped.
- Push: on vld_in=1 and not full, exp_in is written at wr_ptr and wr_ptr increments mod depth.
  - On vld_in=1 while full: no write, overflow<=1.
- Pop: on vld_out=1 and not empty, the head entry is compared with q by exact bit equality and rd_ptr increments. The result is visible one cycle after the vld_out edge:
  - match: pass_cnt++
  - mismatch: fail_cnt++. If err_vld=0, capture err_idx=res_idx, err_exp=head, err_act=q, err_vld<=1. Later failures never overwrite the capture.
  - res_idx increments on every vld_out, including underflow.
- vld_out=1 while empty: underflow<=1; no compare; no counter change other than res_idx.
- Simultaneous push and pop:
  - Non-empty: both occur and pending is unchanged.
  - Full: the pop frees a slot, so the push succeeds and there is no overflow.
  - Empty: no same-cycle bypass; underflow is flagged and the push still succeeds. The formula latency is >= 1 cycle.
- Pointers are $clog2(depth)+1 bits with a wrap bit. Full = MSBs differ and the rest are equal; empty = equal.
- pending = wr_ptr - rd_ptr, registered and consistent with the pointers.
- Counters saturate at all-ones and never wrap. res_idx also saturates.
- Status FSM, registered, updated each clk:
  - S_IDLE (0): pending=0 and no error. Goes to S_BUSY on a successful push. Goes to S_FAIL on any mismatch, overflow or underflow.
  - S_BUSY (1): pending>0. Goes to S_IDLE when pending reaches 0 with no error. Goes to S_FAIL on error.
  - S_FAIL (2): sticky. Exits only via clear or rst, to S_IDLE. FIFO and counters keep operating in S_FAIL.
  - Code 3 is unused and recovers to S_IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package formula_pkg:
  - state enum: S_IDLE, S_BUSY, S_FAIL
  - default width constants: width=8, width_out=2*width+6
  - a saturating-increment function reused by all counters
- Sub-module formula_exp_fifo: synchronous FIFO with parameters width_out and depth, and ports push, pop, din, dout, full, empty, count. The checker instantiates it once and holds the compare, counters, capture and FSM.

Test Plan:
- Reset/idle: hold rst=0 for 2 cycles, then release. All outputs are 0 and state=0, including when rst is asserted mid-run with pending=5.
- Latency-3 pass stream: push exp 100, -50, 0 on consecutive cycles; apply q=100, -50, 0 three cycles later. Result: pass_cnt=3, fail_cnt=0, pending=0, state returns to S_IDLE.
- Single mismatch: push expected values 7, 8, 9; return q=7, 5, 9. Result: fail_cnt=1, pass_cnt=2, err_idx=1, err_exp=8, err_act=5, state=S_FAIL; a second mismatch leaves the capture unchanged.
- Full/overflow (depth=16): 17 pushes with no pops give pending=16 and overflow=1. A push and pop on the same cycle while full gives no new overflow and pending=16.
- Underflow: vld_out=1 with empty FIFO gives underflow=1, res_idx=1, pass_cnt=0, state=S_FAIL. clear=1 then returns everything to 0 and state to S_IDLE.
- Saturation (cnt_w=4): 20 matching results give pass_cnt=15 and res_idx=15, with no wrap.
